// File: rtl/prg_cache_responder_if.sv
// Line-fill read port between the instruction cache and the SDRAM controller.
// Latency: none (bundle of wires); request is level-held until the single-cycle ack.
// Backpressure: the controller stalls the cache by withholding mem_ack; burst words carry no backpressure.
// Ports: mem_req/mem_addr (cache -> controller), mem_ack/mem_rvalid/mem_rdata (controller -> cache).
interface prg_cache_responder_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // master: the cache side issuing line reads
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rvalid,
        input  mem_rdata
    );

    // slave: the SDRAM controller answering them
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/prg_cache_responder.sv
// Direct-mapped line instruction cache answering the CPU fetch unit, refilled by bursts over mem.
// Latency: 1 cycle from prg_address to instruction/p_cache_miss on a hit.
// Backpressure: p_cache_miss=1 tells the requester to hold; mem_req is held until mem_ack.
// Ports: clk, rst (sync, active-low), prg_address, flush -> instruction, p_cache_miss; mem = line-fill port.
module prg_cache_responder #(
    parameter int                INDEX_BITS  = 5,
    parameter int                OFFSET_BITS = 3,
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           prg_address,
    input  logic                  flush,
    output logic [DATA_W-1:0]     instruction,
    output logic                  p_cache_miss,
    prg_cache_responder_if.master mem
);
    localparam int LINES  = 2 ** INDEX_BITS;
    localparam int WORDS  = 2 ** OFFSET_BITS;
    localparam int TAG_W  = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_W = 32 - OFFSET_BITS;
    localparam int RAM_AW = INDEX_BITS + OFFSET_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_RESUME
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_miss;
    logic                    w_miss_nxt;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag [LINES];
    logic [DATA_W-1:0]       r_ram [2**RAM_AW];
    logic [DATA_W-1:0]       r_rd_dat;
    logic [LINE_W-1:0]       r_miss_line;    // line address of the outstanding miss
    logic [OFFSET_BITS-1:0]  r_word_cnt;
    logic                    r_flush_seen;   // a flush landed while this line was in flight

    logic [INDEX_BITS-1:0]   w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic                    w_lookup;
    logic                    w_start_req;
    logic [INDEX_BITS-1:0]   w_fill_idx;
    logic                    w_wr;
    logic                    w_last;

    // Lookup of the address presented this cycle against the tag/valid registers.
    assign w_idx    = prg_address[OFFSET_BITS +: INDEX_BITS];
    assign w_tag    = prg_address[31 -: TAG_W];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // RESUME repeats the lookup one cycle after the last fill write so the sync-read RAM sees it.
    assign w_lookup    = (r_state == S_IDLE) || (r_state == S_RESUME);
    assign w_start_req = w_lookup && !w_hit;

    assign w_fill_idx = r_miss_line[INDEX_BITS-1:0];
    // Burst words count only in FILL; rvalid while waiting for the ack is stray and dropped.
    assign w_wr   = rst && (r_state == S_FILL) && mem.mem_rvalid;
    assign w_last = w_wr && (r_word_cnt == OFFSET_BITS'(WORDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RESUME: w_state_nxt = w_hit ? S_IDLE : S_REQ;
            S_REQ:            if (mem.mem_ack) w_state_nxt = S_FILL;
            S_FILL:           if (w_last) w_state_nxt = S_RESUME;
            default:          w_state_nxt = S_IDLE;
        endcase
        // Anything other than a completed hit leaves the fetch stalled next cycle.
        w_miss_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_miss       <= 1'b0;
            r_miss_line  <= '0;
            r_word_cnt   <= '0;
            r_flush_seen <= 1'b0;
            r_valid      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_miss  <= w_miss_nxt;

            if (w_start_req) begin
                r_miss_line  <= prg_address[31:OFFSET_BITS];
                r_flush_seen <= 1'b0;
            end else if (flush && ((r_state == S_REQ) || (r_state == S_FILL))) begin
                r_flush_seen <= 1'b1;
            end

            if ((r_state == S_REQ) && mem.mem_ack) begin
                r_word_cnt <= '0;
            end else if (w_wr) begin
                r_word_cnt <= r_word_cnt + OFFSET_BITS'(1);
            end

            // Flush beats validation, including when both hit in the same cycle.
            if (flush) begin
                r_valid <= '0;
            end else if (w_last && !r_flush_seen) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_last) begin
            r_tag[w_fill_idx] <= r_miss_line[LINE_W-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram[{w_fill_idx, r_word_cnt}] <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_dat <= NOP_WORD;
        end else begin
            r_rd_dat <= r_ram[{w_idx, prg_address[OFFSET_BITS-1:0]}];
        end
    end

    assign instruction  = r_miss ? NOP_WORD : r_rd_dat;
    assign p_cache_miss = r_miss;
    assign mem.mem_req  = (r_state == S_REQ);
    assign mem.mem_addr = {r_miss_line, {OFFSET_BITS{1'b0}}};

endmodule

// File: tb/tb_prg_cache_responder.sv
// Bench for prg_cache_responder: fetch scoreboard plus a behavioural SDRAM line-read model.
// Latency: fetch results are popped whenever the DUT reports p_cache_miss=0.
// Backpressure: the model can withhold mem_ack and inject stray rvalid, flush and reset.
module tb_prg_cache_responder;
    logic        clk;
    logic        rst;
    logic [31:0] prg_address;
    logic        flush;
    logic [15:0] instruction;
    logic        p_cache_miss;

    prg_cache_responder_if #(.DATA_W(16)) mem_if ();

    prg_cache_responder #(
        .INDEX_BITS (5),
        .OFFSET_BITS(3),
        .DATA_W     (16),
        .NOP_WORD   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prg_address (prg_address),
        .flush       (flush),
        .instruction (instruction),
        .p_cache_miss(p_cache_miss),
        .mem         (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] exp_q[$];      // expected instruction per issued fetch
    logic [31:0] exp_req_q[$];  // expected line address per memory request

    int req_total     = 0;      // requests acked by the model
    int req_drops     = 0;      // mem_req fell before being acked
    int inj_flush_req = -1;
    int inj_flush_word = 0;
    int inj_rst_req   = -1;
    int inj_rst_word  = 0;
    int slow_req      = -1;
    int flush_req_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return 16'hA000 + a[15:0] - 16'h0010;
    endfunction

    // SDRAM controller model: acks requests, streams bursts, injects flush/reset on request.
    initial begin : mem_model
        int          rst_cnt;
        int          burst_cnt;
        int          wait_cnt;
        int          flush_done;
        bit          bursting;
        bit          req_active;
        bit          chk_rst;
        logic [31:0] base;
        rst = 1'b0; flush = 1'b0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
        rst_cnt = 2; burst_cnt = 0; wait_cnt = 0; flush_done = 0;
        bursting = 1'b0; req_active = 1'b0; chk_rst = 1'b0; base = '0;
        forever begin
            @(posedge clk); #2;
            if (chk_rst) begin
                chk("rst_mid_pcm", {31'd0, p_cache_miss}, 32'd0);
                chk("rst_mid_req", {31'd0, mem_if.mem_req}, 32'd0);
                chk_rst = 1'b0;
            end
            mem_if.mem_ack = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0; flush = 1'b0;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst = 1'b1;
            end
            if (flush_req_cnt != flush_done) begin
                flush = 1'b1;
                flush_done++;
            end
            if (bursting) begin
                if (req_total == inj_flush_req && burst_cnt == inj_flush_word) flush = 1'b1;
                if (req_total == inj_rst_req && burst_cnt == inj_rst_word && rst) begin
                    rst = 1'b0; rst_cnt = 2; chk_rst = 1'b1;
                end
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = mem_word(base + 32'(burst_cnt));
                burst_cnt++;
                if (burst_cnt == 8) bursting = 1'b0;
            end else if (rst && mem_if.mem_req) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    wait_cnt = 0;
                end
                if (req_total + 1 == slow_req && wait_cnt < 20) begin
                    wait_cnt++;
                    mem_if.mem_rvalid = 1'b1;
                    mem_if.mem_rdata  = 16'hDEAD;
                end else begin
                    mem_if.mem_ack = 1'b1;
                    if (exp_req_q.size() > 0) chk("mem_addr", mem_if.mem_addr, exp_req_q.pop_front());
                    else chk("unexpected_req", 32'(exp_req_q.size()), 32'd1);
                    req_total++;
                    req_active = 1'b0;
                    bursting = 1'b1;
                    burst_cnt = 0;
                    base = mem_if.mem_addr;
                end
            end else if (req_active) begin
                req_drops++;
                req_active = 1'b0;
            end
        end
    end

    // Issue one fetch and hold it until the DUT delivers; returns latency and first-cycle outputs.
    task automatic fetch(input logic [31:0] a, output int lat, output logic first_pcm,
                         output logic [15:0] first_ins);
        bit done;
        exp_q.push_back(mem_word(a));
        prg_address = a;
        lat = 0; done = 1'b0; first_pcm = 1'b0; first_ins = '0;
        while (!done) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                first_pcm = p_cache_miss;
                first_ins = instruction;
            end
            if (rst && !p_cache_miss) begin
                chk("instr", {16'd0, instruction}, {16'd0, exp_q.pop_front()});
                done = 1'b1;
            end else if (lat > 400) begin
                chk("fetch_timeout", 32'(lat), 32'd0);
                void'(exp_q.pop_front());
                done = 1'b1;
            end
        end
    endtask

    initial begin : main
        int          lat;
        int          r0;
        logic        fp;
        logic [15:0] fi;
        prg_address = 32'h0000_0010;

        @(posedge clk); #1;
        chk("rst_pcm", {31'd0, p_cache_miss}, 32'd0);
        chk("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("rst_addr", mem_if.mem_addr, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'h0000);
        while (!rst) begin @(posedge clk); #1; end

        // cold miss
        r0 = req_total;
        exp_req_q.push_back(32'h10);
        fetch(32'h10, lat, fp, fi);
        chk("t1_first_pcm", {31'd0, fp}, 32'd1);
        chk("t1_first_nop", {16'd0, fi}, 32'h0000);
        chk("t1_reqs", 32'(req_total - r0), 32'd1);

        // sequential hits, one cycle each
        r0 = req_total;
        for (int i = 1; i < 8; i++) begin
            fetch(32'h10 + 32'(i), lat, fp, fi);
            chk("t2_hit_lat", 32'(lat), 32'd1);
        end
        chk("t2_reqs", 32'(req_total - r0), 32'd0);

        // conflict on the same index
        r0 = req_total;
        exp_req_q.push_back(32'h110);
        fetch(32'h110, lat, fp, fi);
        chk("t3_conf_pcm", {31'd0, fp}, 32'd1);
        exp_req_q.push_back(32'h10);
        fetch(32'h10, lat, fp, fi);
        chk("t3_back_pcm", {31'd0, fp}, 32'd1);
        chk("t3_reqs", 32'(req_total - r0), 32'd2);

        // flush in the middle of a fill
        r0 = req_total;
        inj_flush_req = req_total + 1; inj_flush_word = 3;
        exp_req_q.push_back(32'h20); exp_req_q.push_back(32'h20);
        fetch(32'h20, lat, fp, fi);
        chk("t4_reqs", 32'(req_total - r0), 32'd2);
        fetch(32'h21, lat, fp, fi);
        chk("t4_hit_lat", 32'(lat), 32'd1);

        // flush together with the last burst word
        r0 = req_total;
        inj_flush_req = req_total + 1; inj_flush_word = 7;
        exp_req_q.push_back(32'h40); exp_req_q.push_back(32'h40);
        fetch(32'h40, lat, fp, fi);
        chk("t4b_reqs", 32'(req_total - r0), 32'd2);
        fetch(32'h41, lat, fp, fi);
        chk("t4b_hit_lat", 32'(lat), 32'd1);

        // flush while idle: the resident line must refetch
        flush_req_cnt++;
        repeat (2) begin @(posedge clk); #1; end
        r0 = req_total;
        exp_req_q.push_back(32'h40);
        fetch(32'h42, lat, fp, fi);
        chk("t4c_pcm", {31'd0, fp}, 32'd1);
        chk("t4c_reqs", 32'(req_total - r0), 32'd1);

        // stalled ack with stray rvalid pulses
        r0 = req_total;
        slow_req = req_total + 1;
        exp_req_q.push_back(32'h50);
        fetch(32'h50, lat, fp, fi);
        chk("t5_req_held", 32'(req_drops), 32'd0);
        chk("t5_reqs", 32'(req_total - r0), 32'd1);
        fetch(32'h57, lat, fp, fi);
        chk("t5_hit_lat", 32'(lat), 32'd1);

        // reset in the middle of a fill
        r0 = req_total;
        inj_rst_req = req_total + 1; inj_rst_word = 4;
        exp_req_q.push_back(32'h30); exp_req_q.push_back(32'h30);
        fetch(32'h30, lat, fp, fi);
        chk("t6_reqs", 32'(req_total - r0), 32'd2);

        // top of the address space
        exp_req_q.push_back(32'hFFFF_FFF8);
        fetch(32'hFFFF_FFFF, lat, fp, fi);
        fetch(32'hFFFF_FFF8, lat, fp, fi);
        chk("t7_hit_lat", 32'(lat), 32'd1);

        chk("req_q_left", 32'(exp_req_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
